// File: rtl/coll_det_pkg.sv
// Shared FSM encoding, width helpers and schedule length for the collision-detect pipe.
// Width helpers take W so every file derives identical datapath widths from one place.
package coll_det_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_DIFF = 3'd1;
  localparam state_t S_MUL1 = 3'd2;
  localparam state_t S_SUM  = 3'd3;
  localparam state_t S_MUL2 = 3'd4;
  localparam state_t S_CMP  = 3'd5;

  // Per-axis difference width (W+1), accumulated-sum width (2W+4), final product width (4W+8).
  function automatic int diff_w(input int w);
    return w + 1;
  endfunction

  function automatic int acc_w(input int w);
    return 2 * w + 4;
  endfunction

  function automatic int wide_w(input int w);
    return 4 * w + 8;
  endfunction

  // Two products per cycle: 6 products for 2-D, 9 for 3-D.
  function automatic int mul1_cycles(input int dim);
    return (dim == 3) ? 5 : 3;
  endfunction

endpackage

// File: rtl/coll_det_mul.sv
// Combinational signed multiplier, full-width AW+BW product; no latency, no flow control.
// Operands are sign-extended first so the product never truncates.
module coll_det_mul #(
  parameter int AW = 8,
  parameter int BW = 8
) (
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [AW+BW-1:0] p
);

  logic signed [AW+BW-1:0] a_ext;
  logic signed [AW+BW-1:0] b_ext;

  assign a_ext = {{BW{a[AW-1]}}, a};
  assign b_ext = {{AW{b[BW-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/coll_det_pipe.sv
// Collision/approach test for two moving points; result 8 (2-D) or 10 (3-D) cycles after accept.
// Single request in flight: in_rdy is ignored while busy, out_rdy pulses once per result.
module coll_det_pipe
  import coll_det_pkg::*;
#(
  parameter int W   = 16,
  parameter int DIM = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_rdy,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] z1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] z2,
  input  logic [W-1:0] vx1,
  input  logic [W-1:0] vy1,
  input  logic [W-1:0] vz1,
  input  logic [W-1:0] vx2,
  input  logic [W-1:0] vy2,
  input  logic [W-1:0] vz2,
  input  logic [W-1:0] r2,
  output logic         busy,
  output logic         hit,
  output logic         approaching,
  output logic         out_rdy
);

  localparam int DW = diff_w(W);
  localparam int AW = acc_w(W);
  localparam int WW = wide_w(W);
  localparam int PW = 2 * DW;
  localparam int N1 = mul1_cycles(DIM);

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic signed [W-1:0]  p1_q [3];
  logic signed [W-1:0]  p1_d [3];
  logic signed [W-1:0]  p2_q [3];
  logic signed [W-1:0]  p2_d [3];
  logic signed [W-1:0]  v1_q [3];
  logic signed [W-1:0]  v1_d [3];
  logic signed [W-1:0]  v2_q [3];
  logic signed [W-1:0]  v2_d [3];
  logic [W-1:0]         r2_q, r2_d;

  logic signed [DW-1:0] d_q  [3];
  logic signed [DW-1:0] d_d  [3];
  logic signed [DW-1:0] dv_q [3];
  logic signed [DW-1:0] dv_d [3];

  logic signed [PW-1:0] prod_q [10];
  logic signed [PW-1:0] prod_d [10];

  logic signed [AW-1:0] r_sq_q, r_sq_d;
  logic signed [AW-1:0] v_sq_q, v_sq_d;
  logic signed [AW-1:0] k_q, k_d;

  logic signed [WW-1:0] rv_q, rv_d;
  logic signed [WW-1:0] kk_q, kk_d;
  logic signed [WW-1:0] m_q, m_d;
  logic signed [WW-1:0] n_q, n_d;

  logic hit_q, hit_d;
  logic appr_q, appr_d;
  logic out_rdy_q, out_rdy_d;

  logic signed [AW-1:0] r2_ext;
  logic signed [DW-1:0] sl_a [10];
  logic signed [DW-1:0] sl_b [10];
  logic signed [AW-1:0] ma_a, ma_b, mb_a, mb_b;
  logic signed [WW-1:0] ma_p, mb_p;

  assign r2_ext = $signed({{(AW-W){1'b0}}, r2_q});

  coll_det_mul #(.AW(AW), .BW(AW)) u_mul_a (.a(ma_a), .b(ma_b), .p(ma_p));
  coll_det_mul #(.AW(AW), .BW(AW)) u_mul_b (.a(mb_a), .b(mb_b), .p(mb_p));

  // Product slots per axis: d*d, dv*dv, d*dv; slot 9 is a spare zero product.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      sl_a[i] = '0;
      sl_b[i] = '0;
    end
    for (int a = 0; a < 3; a++) begin
      sl_a[3*a]   = d_q[a];
      sl_b[3*a]   = d_q[a];
      sl_a[3*a+1] = dv_q[a];
      sl_b[3*a+1] = dv_q[a];
      sl_a[3*a+2] = d_q[a];
      sl_b[3*a+2] = dv_q[a];
    end
  end

  always_comb begin
    ma_a = '0;
    ma_b = '0;
    mb_a = '0;
    mb_b = '0;
    case (state_q)
      S_MUL1: begin
        for (int c = 0; c < 5; c++) begin
          if (cnt_q == 3'(c)) begin
            ma_a = AW'(sl_a[2*c]);
            ma_b = AW'(sl_b[2*c]);
            mb_a = AW'(sl_a[2*c+1]);
            mb_b = AW'(sl_b[2*c+1]);
          end
        end
      end
      S_MUL2: begin
        if (cnt_q == 3'd0) begin
          ma_a = r_sq_q;
          ma_b = v_sq_q;
          mb_a = k_q;
          mb_b = k_q;
        end else begin
          ma_a = v_sq_q;
          ma_b = r2_ext;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    r2_d      = r2_q;
    d_d       = d_q;
    dv_d      = dv_q;
    prod_d    = prod_q;
    r_sq_d    = r_sq_q;
    v_sq_d    = v_sq_q;
    k_d       = k_q;
    rv_d      = rv_q;
    kk_d      = kk_q;
    m_d       = m_q;
    n_d       = n_q;
    hit_d     = hit_q;
    appr_d    = appr_q;
    out_rdy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_rdy) begin
          // z is forced to zero in 2-D so the shared 3-axis datapath ignores it.
          p1_d[0] = x1;
          p1_d[1] = y1;
          p1_d[2] = (DIM == 3) ? z1 : '0;
          p2_d[0] = x2;
          p2_d[1] = y2;
          p2_d[2] = (DIM == 3) ? z2 : '0;
          v1_d[0] = vx1;
          v1_d[1] = vy1;
          v1_d[2] = (DIM == 3) ? vz1 : '0;
          v2_d[0] = vx2;
          v2_d[1] = vy2;
          v2_d[2] = (DIM == 3) ? vz2 : '0;
          r2_d    = r2;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        for (int a = 0; a < 3; a++) begin
          d_d[a]  = DW'(p2_q[a]) - DW'(p1_q[a]);
          dv_d[a] = DW'(v2_q[a]) - DW'(v1_q[a]);
        end
        cnt_d   = '0;
        state_d = S_MUL1;
      end
      S_MUL1: begin
        for (int c = 0; c < 5; c++) begin
          if (cnt_q == 3'(c)) begin
            prod_d[2*c]   = ma_p[PW-1:0];
            prod_d[2*c+1] = mb_p[PW-1:0];
          end
        end
        if (cnt_q == 3'(N1 - 1)) begin
          cnt_d   = '0;
          state_d = S_SUM;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_SUM: begin
        r_sq_d  = AW'(prod_q[0]) + AW'(prod_q[3]) + AW'(prod_q[6]);
        v_sq_d  = AW'(prod_q[1]) + AW'(prod_q[4]) + AW'(prod_q[7]);
        k_d     = AW'(prod_q[2]) + AW'(prod_q[5]) + AW'(prod_q[8]);
        cnt_d   = '0;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        if (cnt_q == 3'd0) begin
          rv_d  = ma_p;
          kk_d  = mb_p;
          cnt_d = 3'd1;
        end else begin
          n_d     = ma_p;
          m_d     = rv_q - kk_q;
          cnt_d   = '0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        // Closest approach lies in the future only when k < 0; otherwise t=0 is the minimum.
        appr_d    = (k_q < 0);
        hit_d     = (r_sq_q <= r2_ext) || ((k_q < 0) && (m_q <= n_q));
        out_rdy_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r2_q      <= '0;
      r_sq_q    <= '0;
      v_sq_q    <= '0;
      k_q       <= '0;
      rv_q      <= '0;
      kk_q      <= '0;
      m_q       <= '0;
      n_q       <= '0;
      hit_q     <= 1'b0;
      appr_q    <= 1'b0;
      out_rdy_q <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        p1_q[a] <= '0;
        p2_q[a] <= '0;
        v1_q[a] <= '0;
        v2_q[a] <= '0;
        d_q[a]  <= '0;
        dv_q[a] <= '0;
      end
      for (int i = 0; i < 10; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      r2_q      <= r2_d;
      d_q       <= d_d;
      dv_q      <= dv_d;
      prod_q    <= prod_d;
      r_sq_q    <= r_sq_d;
      v_sq_q    <= v_sq_d;
      k_q       <= k_d;
      rv_q      <= rv_d;
      kk_q      <= kk_d;
      m_q       <= m_d;
      n_q       <= n_d;
      hit_q     <= hit_d;
      appr_q    <= appr_d;
      out_rdy_q <= out_rdy_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign hit         = hit_q;
  assign approaching = appr_q;
  assign out_rdy     = out_rdy_q;

endmodule

// File: doc/coll_det_pipe.md
COLL_DET_PIPE -- requirements
Module: coll_det_pipe

Interface
REQ-001 SHALL have parameter W, default 16: signed width of position/velocity components; unsigned width of r2.
REQ-002 SHALL have parameter DIM, default 2: number of spatial dimensions; legal values are 2 and 3.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_rdy, input, 1: request; operands are valid this cycle.
REQ-006 SHALL have ports x1, y1, z1, input, W each: signed position of object 1.
REQ-007 SHALL have ports x2, y2, z2, input, W each: signed position of object 2.
REQ-008 SHALL have ports vx1, vy1, vz1, vx2, vy2, vz2, input, W each: signed velocities of objects 1 and 2.
REQ-009 SHALL ignore all z ports when DIM=2.
REQ-010 SHALL have port r2, input, W: unsigned squared collision radius.
REQ-011 SHALL have port busy, output, 1: high while an operation is in flight.
REQ-012 SHALL have port hit, output, 1: the objects collide now or in the future.
REQ-013 SHALL have port approaching, output, 1: the separation is strictly decreasing.
REQ-014 SHALL have port out_rdy, output, 1: one-cycle pulse; hit and approaching are updated this cycle.

Function
REQ-015 SHALL accept a request on a rising edge where in_rdy=1 and busy=0, and SHALL register all operands on that edge (edge 0).
REQ-016 SHALL ignore in_rdy while busy=1; there is no queue and no error flag.
REQ-017 SHALL compute d = p2 - p1 and dv = v2 - v1 per axis at W+1 signed bits, with no wrap.
REQ-018 SHALL compute three quantities: r_sq = sum of d², v_sq = sum of dv², and k = sum of d*dv (signed), all at full width 2W+4.
REQ-019 SHALL compute m = r_sq*v_sq - k² and n = v_sq*r2 at full width 4W+8, with no truncation at any stage.
REQ-020 SHALL use exactly two signed multiplier instances, time-shared under an FSM.
REQ-021 SHALL implement FSM states IDLE -> DIFF -> MUL1 -> SUM -> MUL2 -> CMP -> IDLE.
REQ-022 SHALL hold MUL1 for 3 cycles when DIM=2 and for 5 cycles when DIM=3, issuing two products per cycle.
REQ-023 SHALL hold MUL2 for 2 cycles, computing r_sq*v_sq, k*k and v_sq*r2.
REQ-024 SHALL assert out_rdy for exactly one cycle, following edge 8 when DIM=2 or edge 10 when DIM=3.
REQ-025 SHALL deassert busy on the same edge that asserts out_rdy, so a new request is accepted on the next edge.
REQ-026 SHALL set approaching = (k < 0).
REQ-027 SHALL set hit = (r_sq <= r2) OR (k < 0 AND m <= n).
REQ-028 SHALL give hit = (r_sq <= r2) when v_sq = 0, because k is then 0.
REQ-029 SHALL hold hit and approaching stable between out_rdy pulses.

Reset
REQ-030 SHALL on reset asynchronously force state=IDLE, busy=0, out_rdy=0, hit=0 and approaching=0, and clear all datapath registers.
REQ-031 SHALL abort any in-flight operation on reset mid-operation; no out_rdy pulse follows for the aborted request.
REQ-032 SHALL accept in_rdy on the first rising edge after reset deasserts.

Structure
REQ-033 SHALL place the FSM state enum, the MUL1 cycle count as a function of DIM, and the width constants (W+1, 2W+4, 4W+8) in shared package coll_det_pkg.
REQ-034 SHALL implement the multiplier as sub-module coll_det_mul: a parametrised combinational signed multiplier, instantiated twice.

Verification
Scenarios below use W=16, DIM=2 unless noted.
REQ-035 Head-on: p1=(0,0), v1=(1,0), p2=(10,0), v2=(0,0), r2=4 -> m=0, hit=1, approaching=1, out_rdy exactly 8 cycles after accept.
REQ-036 Offset pass: p2=(10,5), other operands as REQ-035 -> m=25; r2=4 gives hit=0, approaching=1; r2=25 gives hit=1 (equality boundary).
REQ-037 Receding and static overlap:
- p2=(10,0), v2=(2,0), v1=0, r2=4 -> k=20, hit=0, approaching=0.
- p1=p2=(3,3), all velocities 0, r2=0 -> hit=1, approaching=0.
REQ-038 Extremes: x1=-32768, x2=32767, y=0, velocities 0, r2=65535 -> d=65535 with no overflow, hit=0; repeat with DIM=3, z1=-32768, z2=32767 -> out_rdy after 10 cycles.
REQ-039 Handshake and reset:
- in_rdy held high across an operation -> second request accepted only on the edge after the out_rdy pulse.
- reset pulsed at cycle 4 -> busy=0, no out_rdy, outputs 0.
